// File: rtl/debug_dump_tx_pkg.sv
// debug_pkg: shared constants for the debug snapshot transmitter.
//   HEADER/NREG/NMEM  default frame start byte and dump sizes
//   OFF_*             byte offsets of each field inside a frame
//   FRAME_LEN         total frame length for the default sizes
//   frame_len()       frame length for arbitrary sizes
//   state_e           transmitter FSM states
package debug_pkg;

  localparam logic [7:0] HEADER = 8'hA5;
  localparam int NREG = 32;
  localparam int NMEM = 10;

  localparam int OFF_PC    = 1;
  localparam int OFF_INSTR = 3;
  localparam int OFF_REG   = 7;
  localparam int OFF_MEM   = OFF_REG + 4 * NREG;
  localparam int OFF_CSUM  = OFF_MEM + 4 * NMEM;
  localparam int FRAME_LEN = 1 + 2 + 4 + 4 * NREG + 4 * NMEM + 1;

  function automatic int frame_len(input int nreg, input int nmem);
    return 1 + 2 + 4 + 4 * nreg + 4 * nmem + 1;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHECK   = 2'd3
  } state_e;

endpackage

// File: rtl/debug_dump_tx_if.sv
// debug_dump_tx_if: byte-stream valid/ready link from the dump transmitter
// to its byte sink.
//   tx_data   byte offered to the sink
//   tx_valid  tx_data is valid
//   tx_ready  sink accepts the byte at this edge
interface debug_dump_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/debug_dump_tx_byte_sel.sv
// tx_byte_sel: combinational frame byte selector. Maps a frame byte index
// onto the snapshot fields, all fields sent MSB-first.
//   cnt         frame byte index (0 = header)
//   pc/instr    captured fetch PC and instruction
//   regs/mems   captured register file and data memory (word 0 in low bits)
//   csum        running payload checksum, sent as the last byte
//   frame_byte  selected byte
module tx_byte_sel
  import debug_pkg::*;
#(
  parameter logic [7:0] HDR = HEADER,
  parameter int NR = NREG,
  parameter int NM = NMEM,
  parameter int CNT_W = 8
) (
  input  logic [CNT_W-1:0]  cnt,
  input  logic [9:0]        pc,
  input  logic [31:0]       instr,
  input  logic [32*NR-1:0]  regs,
  input  logic [32*NM-1:0]  mems,
  input  logic [7:0]        csum,
  output logic [7:0]        frame_byte
);

  localparam int MEM0  = OFF_REG + 4 * NR;
  localparam int CSUM0 = MEM0 + 4 * NM;

  logic [15:0] pc_field;
  assign pc_field = {6'b0, pc};

  always_comb begin
    int k;
    int rk;
    int mk;
    k  = int'(cnt);
    rk = k - OFF_REG;
    mk = k - MEM0;
    frame_byte = 8'h00;
    if (k < OFF_PC)         frame_byte = HDR;
    else if (k < OFF_INSTR) frame_byte = pc_field[8*(OFF_INSTR-1-k) +: 8];
    else if (k < OFF_REG)   frame_byte = instr[8*(OFF_REG-1-k) +: 8];
    // word index = offset/4, byte 0 of each word is bits [31:24]
    else if (k < MEM0)      frame_byte = regs[32*(rk/4) + 8*(3-(rk%4)) +: 8];
    else if (k < CSUM0)     frame_byte = mems[32*(mk/4) + 8*(3-(mk%4)) +: 8];
    else if (k == CSUM0)    frame_byte = csum;
  end

endmodule

// File: rtl/debug_dump_tx.sv
// debug_dump_tx: on start, snapshots the pipeline state (PC, instruction,
// register file, data memory) and streams it as one framed byte sequence
// with an XOR checksum, freezing the pipeline clock enable while busy.
//   clk, reset     clock, async active-low reset
//   start          request one snapshot dump (ignored while busy)
//   Registers      register file, reg i = [32i+31:32i]
//   Memorias       data memory, word j = [32j+31:32j]
//   PC_IFID        fetch-stage PC
//   instruction    fetched instruction
//   tx             byte stream (master side)
//   busy           frame in progress
//   done           one-cycle pulse after the checksum byte transfers
//   clkEnable      0 freezes the pipeline while dumping
//
// state     | meaning
// S_IDLE    | no frame; waiting for start
// S_HEADER  | offering the header byte
// S_PAYLOAD | offering PC, instruction, registers, memory bytes
// S_CHECK   | offering the checksum byte
module debug_dump_tx #(
  parameter logic [7:0] HEADER = debug_pkg::HEADER,
  parameter int NREG = debug_pkg::NREG,
  parameter int NMEM = debug_pkg::NMEM
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [32*NREG-1:0]   Registers,
  input  logic [32*NMEM-1:0]   Memorias,
  input  logic [9:0]           PC_IFID,
  input  logic [31:0]          instruction,
  debug_dump_tx_if.master      tx,
  output logic                 busy,
  output logic                 done,
  output logic                 clkEnable
);
  import debug_pkg::*;

  localparam int FLEN = frame_len(NREG, NMEM);
  localparam int CNT_W = $clog2(FLEN);
  localparam logic [CNT_W-1:0] CNT_LAST_PAY = CNT_W'(FLEN - 2);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         csum_q, csum_d;
  logic               done_q, done_d;
  logic [9:0]         pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [32*NREG-1:0] regs_q, regs_d;
  logic [32*NMEM-1:0] mems_q, mems_d;

  logic [7:0] sel_byte;
  logic       valid;
  logic       xfer;

  tx_byte_sel #(
    .HDR   (HEADER),
    .NR    (NREG),
    .NM    (NMEM),
    .CNT_W (CNT_W)
  ) u_byte_sel (
    .cnt        (cnt_q),
    .pc         (pc_q),
    .instr      (instr_q),
    .regs       (regs_q),
    .mems       (mems_q),
    .csum       (csum_q),
    .frame_byte (sel_byte)
  );

  assign valid = (state_q != S_IDLE);
  assign xfer  = valid && tx.tx_ready;

  assign tx.tx_valid = valid;
  assign tx.tx_data  = valid ? sel_byte : 8'h00;
  assign busy        = valid;
  assign clkEnable   = !valid;
  assign done        = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    done_d  = 1'b0;
    pc_d    = pc_q;
    instr_d = instr_q;
    regs_d  = regs_q;
    mems_d  = mems_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HEADER;
          cnt_d   = '0;
          csum_d  = 8'h00;
          pc_d    = PC_IFID;
          instr_d = instruction;
          regs_d  = Registers;
          mems_d  = Memorias;
        end
      end
      S_HEADER: begin
        if (xfer) begin
          state_d = S_PAYLOAD;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          csum_d = csum_q ^ sel_byte;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST_PAY) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      csum_q  <= 8'h00;
      done_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      regs_q  <= '0;
      mems_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      regs_q  <= regs_d;
      mems_q  <= mems_d;
    end
  end

endmodule
